sa_ctrl: RTL
============

SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter NUM_ROWS, default 4, PE array rows.
REQ-002 Parameter NUM_COLS, default 4, PE array columns.
REQ-003 Parameter CNT_W, default 16, width of the activation-vector count.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port i_start, input, 1, request to run one tile; sampled only in IDLE.
REQ-007 Port i_num_act, input, CNT_W, K = number of activation vectors; latched on accepted start.
REQ-008 Port i_acc, input, 1, accumulate onto incoming psums; latched on accepted start.
REQ-009 Port o_busy, output, 1, high in any state other than IDLE.
REQ-010 Port o_done, output, 1, one-cycle completion pulse.
REQ-011 Port o_mode, output, 1, array mode: 0 = weight shift, 1 = compute.
REQ-012 Port o_load_psum, output, 1, array column-input select: 1 = psum buffer, 0 = weight buffer.
REQ-013 Port o_w_rd_en, output, 1, weight buffer read strobe.
REQ-014 Port o_w_rd_addr, output, $clog2(NUM_ROWS) (minimum 1), weight row index.
REQ-015 Port o_act_valid, output, NUM_ROWS, per-row skewed activation-valid.
REQ-016 Port o_act_rd_addr, output, CNT_W, activation vector index issued to the skew stage.
REQ-017 Port o_out_valid, output, NUM_COLS, per-column output-psum-valid.

Function
REQ-018 The FSM SHALL have states IDLE, WLOAD, COMPUTE and DONE.
REQ-019 IDLE with i_start=1 and i_num_act>0 SHALL go to WLOAD next cycle and latch K and i_acc.
REQ-020 IDLE with i_start=1 and i_num_act=0 SHALL go directly to DONE: no weight load, no compute.
REQ-021 WLOAD SHALL last exactly NUM_ROWS cycles with o_mode=0, o_load_psum=0, o_w_rd_en=1.
REQ-022 In WLOAD, o_w_rd_addr SHALL count NUM_ROWS-1 down to 0, bottom-row weights first.
REQ-023 COMPUTE SHALL last exactly K+NUM_ROWS+NUM_COLS-1 cycles, indexed t = 0 upward, with o_mode=1 and o_load_psum = latched i_acc.
REQ-024 In COMPUTE, o_act_valid[r] SHALL be 1 iff r <= t < r+K.
REQ-025 In COMPUTE, o_act_rd_addr SHALL equal t while t < K, else hold K-1.
REQ-026 In COMPUTE, o_out_valid[c] SHALL be 1 iff NUM_ROWS+c <= t < NUM_ROWS+c+K.
REQ-027 DONE SHALL last one cycle with o_done=1, then go to IDLE.
REQ-028 i_start SHALL be ignored while o_busy=1.
REQ-029 i_start may be re-asserted in the IDLE cycle following DONE and SHALL be accepted there.
REQ-030 All outputs SHALL be decoded from registered state/counters only, with no combinational input-to-output path.
REQ-031 Outside their active states, o_w_rd_en, o_act_valid, o_out_valid and o_done SHALL be 0.
REQ-032 Counters SHALL support K = 2^CNT_W-1 without overflow; the COMPUTE counter SHALL be CNT_W+1 bits or wider as needed.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, with all outputs 0 and all counters and latches 0, including mid-WLOAD or mid-COMPUTE.
REQ-034 After rst_n deasserts, no o_done SHALL be produced for an aborted run.

Structure
REQ-035 The FSM state enum typedef SHALL reside in the shared package sa_pkg.
REQ-036 Window compares (REQ-024, REQ-026) SHALL use one generate loop per vector, with no sub-module required.
REQ-037 The block SHALL contain no datapath storage; it drives sa_compute and the buffers' control only.

Verification (NUM_ROWS=NUM_COLS=4)
REQ-038 Start at cycle 0 with K=3 -> WLOAD cycles 1-4 with addr 3,2,1,0; COMPUTE cycles 5-14; o_done at cycle 15.
REQ-039 Same run -> o_act_valid[2] high at t=2..4; o_out_valid[3] high at t=7..9; o_out_valid[0] high at t=4..6.
REQ-040 Start with K=0 -> o_done at cycle 1, and o_w_rd_en, o_act_valid and o_out_valid never asserted.
REQ-041 Start with i_acc=1 -> o_load_psum=1 throughout COMPUTE only; a second i_start during COMPUTE has no effect.
REQ-042 rst_n pulsed low at t=5 of COMPUTE -> all outputs 0 asynchronously; the next start with K=1 runs cleanly (COMPUTE 8 cycles).
REQ-043 Back-to-back run: i_start held high continuously -> the second run accepted in the IDLE cycle after DONE, with identical timing.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types for the systolic-array controller: FSM state encoding.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WLOAD   = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } sa_state_e;

endpackage

// File: rtl/sa_ctrl.sv
// Systolic-array tile controller: weight shift-in, skewed activation issue,
// and per-column output-valid windows, all decoded from registered state.
module sa_ctrl
  import sa_pkg::*;
#(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int CNT_W    = 16,
  localparam int AW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_num_act,
  input  logic                i_acc,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_mode,
  output logic                o_load_psum,
  output logic                o_w_rd_en,
  output logic [AW-1:0]       o_w_rd_addr,
  output logic [NUM_ROWS-1:0] o_act_valid,
  output logic [CNT_W-1:0]    o_act_rd_addr,
  output logic [NUM_COLS-1:0] o_out_valid
);

  // Wide enough for t up to K+NUM_ROWS+NUM_COLS-2 with K at its maximum.
  localparam int TW = CNT_W + $clog2(NUM_ROWS + NUM_COLS) + 1;

  sa_state_e        r_state;
  logic [CNT_W-1:0] r_k;
  logic             r_acc;
  logic [AW-1:0]    r_wcnt;
  logic [TW-1:0]    r_t;

  logic [TW-1:0] w_k_ext;
  logic          w_last_t;
  logic          w_wload;
  logic          w_compute;

  assign w_k_ext   = TW'(r_k);
  assign w_last_t  = (r_t == w_k_ext + TW'(NUM_ROWS + NUM_COLS - 2));
  assign w_wload   = (r_state == ST_WLOAD);
  assign w_compute = (r_state == ST_COMPUTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_acc   <= 1'b0;
      r_wcnt  <= '0;
      r_t     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_k    <= i_num_act;
            r_acc  <= i_acc;
            r_wcnt <= AW'(NUM_ROWS - 1);
            r_t    <= '0;
            r_state <= (i_num_act == '0) ? ST_DONE : ST_WLOAD;
          end
        end
        ST_WLOAD: begin
          if (r_wcnt == '0) begin
            r_t     <= '0;
            r_state <= ST_COMPUTE;
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (w_last_t) r_state <= ST_DONE;
          else          r_t     <= r_t + 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_k     <= '0;
          r_acc   <= 1'b0;
          r_wcnt  <= '0;
          r_t     <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_mode        = w_compute;
  assign o_load_psum   = w_compute & r_acc;
  assign o_w_rd_en     = w_wload;
  assign o_w_rd_addr   = w_wload ? r_wcnt : '0;
  assign o_act_rd_addr = !w_compute      ? '0 :
                         (r_t < w_k_ext) ? r_t[CNT_W-1:0] : (r_k - 1'b1);

  // Row r sees its K activations starting r cycles late (input skew).
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_act
    assign o_act_valid[gi] = w_compute && (r_t >= TW'(gi)) &&
                             (r_t < TW'(gi) + w_k_ext);
  end

  // Column c drains after the full row depth plus its own column skew.
  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_out
    assign o_out_valid[gi] = w_compute && (r_t >= TW'(NUM_ROWS + gi)) &&
                             (r_t < TW'(NUM_ROWS + gi) + w_k_ext);
  end

endmodule
